// File: rtl/knock_pkg.sv
// Shared types and widths for the node link endpoint.
package knock_pkg;
    localparam int FLIT_W = 16;
    localparam int CNT_W  = 16;
    typedef logic [FLIT_W-1:0] flit_t;
endpackage

// File: rtl/flit_fifo.sv
// Synchronous flit FIFO; pointers carry an extra wrap bit so full/empty need no extra flag.
module flit_fifo
    import knock_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  flit_t        data,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  count,
    output flit_t        head
);
    flit_t       mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // Pointer update; caller guarantees no push into a full FIFO unless it also pops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage write; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= data;
    end

    // Occupancy flags and head read.
    always_comb begin
        count = wr_ptr - rd_ptr;
        empty = (wr_ptr == rd_ptr);
        full  = (count == (AW+1)'(DEPTH));
        head  = mem[rd_ptr[AW-1:0]];
    end
endmodule

// File: rtl/node_link_endpoint.sv
// Node-side link endpoint: TX queue with registered launch under far-end backpressure,
// RX queue with early buffer_full_out, and per-direction flit counters.
module node_link_endpoint
    import knock_pkg::*;
#(
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 8,
    parameter int RX_SLACK = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  flit_t            tx_data,
    output logic             sending_data,
    output flit_t            data_out,
    input  logic             buffer_full_in,
    input  logic             receiving_data,
    input  flit_t            data_in,
    output logic             buffer_full_out,
    output logic             rx_valid,
    input  logic             rx_ready,
    output flit_t            rx_data,
    output logic             rx_overflow,
    output logic [CNT_W-1:0] tx_count,
    output logic [CNT_W-1:0] rx_count
);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);

    logic           tx_full, tx_empty, tx_push, tx_pop;
    logic [TX_AW:0] tx_level_unused;
    flit_t          tx_head;
    logic           rx_full, rx_empty, rx_push, rx_pop, rx_drop;
    logic [RX_AW:0] rx_occ, rx_next;
    flit_t          rx_head;

    flit_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop), .data(tx_data),
        .full(tx_full), .empty(tx_empty), .count(tx_level_unused), .head(tx_head)
    );

    flit_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .push(rx_push), .pop(rx_pop), .data(data_in),
        .full(rx_full), .empty(rx_empty), .count(rx_occ), .head(rx_head)
    );

    // Handshakes; tx_ready ignores the same-cycle launch, while RX may refill a slot freed this cycle.
    always_comb begin
        tx_ready = !tx_full;
        tx_push  = tx_valid && !tx_full;
        tx_pop   = !tx_empty && !buffer_full_in;
        rx_valid = !rx_empty;
        rx_data  = rx_head;
        rx_pop   = !rx_empty && rx_ready;
        rx_push  = receiving_data && (!rx_full || rx_pop);
        rx_drop  = receiving_data && rx_full && !rx_pop;
        rx_next  = rx_occ + {{RX_AW{1'b0}}, rx_push} - {{RX_AW{1'b0}}, rx_pop};
    end

    // Registered link launch and sent-flit counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sending_data <= 1'b0;
            data_out     <= '0;
            tx_count     <= '0;
        end else if (tx_pop) begin
            sending_data <= 1'b1;
            data_out     <= tx_head;
            tx_count     <= tx_count + CNT_W'(1);
        end else begin
            sending_data <= 1'b0;
            data_out     <= '0;
        end
    end

    // Receive-side status: threshold on next occupancy leaves RX_SLACK slots for in-flight flits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buffer_full_out <= 1'b0;
            rx_overflow     <= 1'b0;
            rx_count        <= '0;
        end else begin
            buffer_full_out <= (rx_next >= (RX_AW+1)'(RX_DEPTH - RX_SLACK));
            if (rx_drop) rx_overflow <= 1'b1;
            if (rx_push) rx_count <= rx_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_node_link_endpoint.sv
// Self-checking bench: queue-based reference model checked every cycle, a hand-derived
// vector table for the first TX burst, and directed sequences for the corner cases.
module tb_node_link_endpoint;
    import knock_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        tx_valid, tx_ready, sending_data, buffer_full_in;
    flit_t       tx_data, data_out, data_in, rx_data;
    logic        receiving_data, buffer_full_out, rx_valid, rx_ready, rx_overflow;
    logic [15:0] tx_count, rx_count;

    always #5 clk = ~clk;

    node_link_endpoint dut (
        .clk(clk), .reset(reset),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .sending_data(sending_data), .data_out(data_out), .buffer_full_in(buffer_full_in),
        .receiving_data(receiving_data), .data_in(data_in), .buffer_full_out(buffer_full_out),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .rx_overflow(rx_overflow),
        .tx_count(tx_count), .rx_count(rx_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state (expected queues act as scoreboards).
    flit_t       txq[$];
    flit_t       rxq[$];
    logic        m_send, m_bfo, m_ovf;
    flit_t       m_dout;
    logic [15:0] m_txc, m_rxc;
    flit_t       sent[$];

    typedef struct {
        logic  tv;
        flit_t td;
        logic  exp_rdy;
        logic  exp_send;
        flit_t exp_dout;
    } vec_t;
    vec_t tbl[6];

    always @(negedge clk) if (sending_data === 1'b1) sent.push_back(data_out);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        txq.delete(); rxq.delete();
        m_send = 1'b0; m_bfo = 1'b0; m_ovf = 1'b0; m_dout = '0;
        m_txc = '0; m_rxc = '0;
    endtask

    task automatic cyc_pre();
        @(negedge clk);
        chk("tx_ready", tx_ready, (txq.size() < 4));
        chk("sending_data", sending_data, m_send);
        chk("data_out", data_out, m_dout);
        chk("buffer_full_out", buffer_full_out, m_bfo);
        chk("rx_overflow", rx_overflow, m_ovf);
        chk("tx_count", tx_count, m_txc);
        chk("rx_count", rx_count, m_rxc);
        chk("rx_valid", rx_valid, (rxq.size() != 0));
        if (rxq.size() != 0) chk("rx_data", rx_data, rxq[0]);
    endtask

    task automatic cyc_post();
        bit launch, tpush, rpop, rfull;
        launch = (txq.size() != 0) && !buffer_full_in;
        tpush  = tx_valid && (txq.size() < 4);
        rpop   = (rxq.size() != 0) && rx_ready;
        rfull  = (rxq.size() == 8);
        if (launch) begin
            m_dout = txq.pop_front();
            m_send = 1'b1;
            m_txc  = m_txc + 16'd1;
        end else begin
            m_send = 1'b0;
            m_dout = '0;
        end
        if (tpush) txq.push_back(tx_data);
        if (rpop) void'(rxq.pop_front());
        if (receiving_data) begin
            if (!rfull || rpop) begin
                rxq.push_back(data_in);
                m_rxc = m_rxc + 16'd1;
            end else begin
                m_ovf = 1'b1;
            end
        end
        m_bfo = (rxq.size() >= 6);
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        cyc_pre();
        cyc_post();
    endtask

    task automatic idle_inputs();
        tx_valid = 1'b0; tx_data = '0; buffer_full_in = 1'b0;
        receiving_data = 1'b0; data_in = '0; rx_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        tbl[0] = '{1'b1, 16'h0001, 1'b1, 1'b0, 16'h0000};
        tbl[1] = '{1'b1, 16'h0002, 1'b1, 1'b0, 16'h0000};
        tbl[2] = '{1'b1, 16'h0003, 1'b1, 1'b1, 16'h0001};
        tbl[3] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0002};
        tbl[4] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0003};
        tbl[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000};

        reset = 1'b1;
        idle_inputs();
        model_reset();
        #1;
        chk("rst_tx_ready", tx_ready, 1'b1);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_sending", sending_data, 1'b0);
        chk("rst_bfo", buffer_full_out, 1'b0);
        chk("rst_tx_count", tx_count, 16'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Three-flit burst from the vector table.
        for (int i = 0; i < 6; i++) begin
            tx_valid = tbl[i].tv;
            tx_data  = tbl[i].td;
            cyc_pre();
            chk("tbl_tx_ready", tx_ready, tbl[i].exp_rdy);
            chk("tbl_sending", sending_data, tbl[i].exp_send);
            chk("tbl_data_out", data_out, tbl[i].exp_dout);
            cyc_post();
        end
        chk("tbl_tx_count", tx_count, 16'd3);

        // Backpressure: fill TX while far end is full, then release.
        do_reset();
        buffer_full_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tx_valid = 1'b1;
            tx_data  = flit_t'(16'hB000 + i);
            cyc();
        end
        cyc_pre();
        chk("bp_tx_ready_low", tx_ready, 1'b0);
        chk("bp_no_send", sending_data, 1'b0);
        cyc_post();
        sent.delete();
        buffer_full_in = 1'b0;
        cyc();
        cyc();
        tx_valid = 1'b0;
        for (int i = 0; i < 6; i++) cyc();
        chk("bp_sent_count", sent.size(), 5);
        for (int i = 0; i < 5 && i < sent.size(); i++)
            chk("bp_sent_order", sent[i], flit_t'(16'hB000 + i));

        // RX threshold: six flits with the core stalled.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            receiving_data = 1'b1;
            data_in = flit_t'(16'hA000 + i);
            cyc_pre();
            if (i == 5) chk("rx_bfo_before", buffer_full_out, 1'b0);
            cyc_post();
        end
        receiving_data = 1'b0;
        cyc_pre();
        chk("rx_bfo_at6", buffer_full_out, 1'b1);
        cyc_post();
        rx_ready = 1'b1;
        for (int i = 0; i < 7; i++) cyc();
        chk("rx_drained", rx_valid, 1'b0);
        chk("rx_no_ovf", rx_overflow, 1'b0);

        // RX full: push with concurrent pop, then a dropped flit.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            receiving_data = 1'b1;
            data_in = flit_t'(16'hC000 + i);
            cyc();
        end
        chk("full_rx_count8", rx_count, 16'd8);
        rx_ready = 1'b1;
        data_in  = 16'hC0FF;
        cyc();
        rx_ready = 1'b0;
        chk("full_pushpop_no_ovf", rx_overflow, 1'b0);
        chk("full_pushpop_count", rx_count, 16'd9);
        data_in = 16'hDEAD;
        cyc();
        receiving_data = 1'b0;
        chk("drop_ovf", rx_overflow, 1'b1);
        chk("drop_count", rx_count, 16'd9);
        cyc();
        chk("ovf_sticky", rx_overflow, 1'b1);
        rx_ready = 1'b1;
        for (int i = 0; i < 9; i++) cyc();
        chk("full_drained", rx_valid, 1'b0);

        // Asynchronous reset with both queues holding flits.
        do_reset();
        buffer_full_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tx_valid = (i < 2);
            tx_data  = flit_t'(16'hE000 + i);
            receiving_data = 1'b1;
            data_in  = flit_t'(16'hF000 + i);
            cyc();
        end
        idle_inputs();
        buffer_full_in = 1'b0;
        cyc();
        #2;
        reset = 1'b1;
        #1;
        chk("arst_tx_ready", tx_ready, 1'b1);
        chk("arst_rx_valid", rx_valid, 1'b0);
        chk("arst_sending", sending_data, 1'b0);
        chk("arst_data_out", data_out, 16'h0000);
        chk("arst_bfo", buffer_full_out, 1'b0);
        chk("arst_counts", {tx_count, rx_count}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
